// File: rtl/shift_right_seq_pkg.sv
// Shared constants, state encoding and stage-select helper for the sequential right shifter.
package shift_right_seq_pkg;

   localparam int WIDTH      = 32;
   localparam int SHAMT_W    = 5;
   localparam int NUM_STAGES = 5;
   localparam int CNT_W      = 3;

   localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(NUM_STAGES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   // Stage 0 shifts by 16 and is gated by shamt[4], down to stage 4 shifting by 1 under shamt[0].
   function automatic logic stage_enable(input logic [SHAMT_W-1:0] amt,
                                         input logic [CNT_W-1:0]   cnt);
      logic en;
      case (cnt)
         3'd0:    en = amt[4];
         3'd1:    en = amt[3];
         3'd2:    en = amt[2];
         3'd3:    en = amt[1];
         3'd4:    en = amt[0];
         default: en = 1'b0;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/shift_right_seq_shr_stage.sv
// One barrel-shifter stage: right shift by 16/8/4/2/1 (selected by stage index) with a fill bit, or pass-through.
module shr_stage
   import shift_right_seq_pkg::*;
(
   input  logic [WIDTH-1:0] data_in,
   input  logic [CNT_W-1:0] stage_idx,
   input  logic             enable,
   input  logic             fill,
   output logic [WIDTH-1:0] data_out
);

   logic [WIDTH-1:0] sh16;
   logic [WIDTH-1:0] sh8;
   logic [WIDTH-1:0] sh4;
   logic [WIDTH-1:0] sh2;
   logic [WIDTH-1:0] sh1;
   logic [WIDTH-1:0] shifted;

   // Build every candidate shift, then choose one through a chain of 2:1 muxes and a final bypass mux.
   always_comb begin
      sh16 = {{16{fill}}, data_in[WIDTH-1:16]};
      sh8  = {{8{fill}},  data_in[WIDTH-1:8]};
      sh4  = {{4{fill}},  data_in[WIDTH-1:4]};
      sh2  = {{2{fill}},  data_in[WIDTH-1:2]};
      sh1  = {fill,       data_in[WIDTH-1:1]};
      shifted = (stage_idx == 3'd0) ? sh16 :
                (stage_idx == 3'd1) ? sh8  :
                (stage_idx == 3'd2) ? sh4  :
                (stage_idx == 3'd3) ? sh2  :
                (stage_idx == 3'd4) ? sh1  : data_in;
      data_out = enable ? shifted : data_in;
   end

endmodule

// File: rtl/shift_right_seq.sv
// Sequential 32-bit right shifter: one barrel stage per cycle, fixed 5-cycle latency, start/ready/done handshake.
module shift_right_seq
   import shift_right_seq_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               arith,
   output logic [WIDTH-1:0]   result,
   output logic               ready,
   output logic               done
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [SHAMT_W-1:0] shamt_q, shamt_d;
   logic               fill_q, fill_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   stage_out;

   shr_stage u_stage (
      .data_in   (work_q),
      .stage_idx (cnt_q),
      .enable    (stage_enable(shamt_q, cnt_q)),
      .fill      (fill_q),
      .data_out  (stage_out)
   );

   // Next-state logic: capture on accepted start, walk the five stages, publish the result on the last one.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      work_d   = work_q;
      result_d = result_q;
      shamt_d  = shamt_q;
      fill_d   = fill_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               work_d  = data_in;
               shamt_d = shamt;
               fill_d  = arith & data_in[WIDTH-1];
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cnt_q > LAST_STAGE) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               work_d = stage_out;
               if (cnt_q == LAST_STAGE) begin
                  result_d = stage_out;
                  done_d   = 1'b1;
                  state_d  = ST_DONE;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
      ready_d = (state_d != ST_SHIFT);
   end

   // All state and the registered handshake outputs; reset aborts any operation in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         work_q   <= '0;
         result_q <= '0;
         shamt_q  <= '0;
         fill_q   <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         work_q   <= work_d;
         result_q <= result_d;
         shamt_q  <= shamt_d;
         fill_q   <= fill_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
      end
   end

   assign result = result_q;
   assign ready  = ready_q;
   assign done   = done_q;

endmodule

// File: doc/shift_right_seq.md
SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 SHALL have port: clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request; sampled only when ready=1.
REQ-004 SHALL have port: data_in  input  32  operand, captured on accepted start.
REQ-005 SHALL have port: shamt  input  5  right-shift amount 0..31, captured on accepted start.
REQ-006 SHALL have port: arith  input  1  1=arithmetic (sign fill), 0=logical (zero fill), captured on accepted start.
REQ-007 SHALL have port: result  output  32  shifted value; held stable from done until the next accepted start.
REQ-008 SHALL have port: ready  output  1  high in IDLE and DONE; start is accepted only then.
REQ-009 SHALL have port: done  output  1  high for exactly one cycle when result becomes valid.

Function
REQ-010 SHALL implement states IDLE, SHIFT, DONE.
REQ-011 Start accepted (start=1, ready=1) at edge k SHALL capture data_in, shamt, arith, set the stage counter to 0, and enter SHIFT.
REQ-012 In SHIFT, each edge SHALL apply one stage in the order 16, 8, 4, 2, 1, shifting right by that amount only if the matching shamt bit (4..0) is set, else passing the value through.
REQ-013 The fill for vacated MSBs SHALL be the captured operand bit 31 when arith=1, else 0.
REQ-014 After the stage-1 edge (k+5), the block SHALL enter DONE; done=1 and result valid during cycle k+5..k+6; latency is fixed at 5 cycles regardless of shamt.
REQ-015 From DONE, the next edge SHALL go to IDLE if start=0, or to SHIFT with new captured inputs if start=1 (back-to-back accepted).
REQ-016 start while in SHIFT SHALL be ignored, with no effect on the operation in flight or on the captured inputs.
REQ-017 The stage counter SHALL be 3 bits, count 0..4, and never wrap past 4; a counter value >4 SHALL force IDLE.
REQ-018 Any illegal state encoding SHALL return to IDLE on the next edge.
REQ-019 result SHALL equal the logical (>>) or arithmetic (>>>) right shift of data_in by shamt, bit-exact for all 32-bit inputs.

Reset
REQ-020 reset=1 SHALL immediately force state=IDLE, counter=0, result=32'h0, done=0, ready=1, regardless of the clock.
REQ-021 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL be produced for it.
REQ-022 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-023 State encoding (2-bit IDLE/SHIFT/DONE), the stage count (5), and the width (32) SHALL live in a shared package.
REQ-024 One sub-module, shr_stage (32-bit conditional right shift by a selectable power-of-two amount 1/2/4/8/16 with a fill bit, built from 2:1 muxes), SHALL perform the per-cycle datapath; the FSM and registers SHALL stay in shift_right_seq.

Verification
REQ-025 SRL: data_in=32'h80000000, shamt=31, arith=0, start at edge k -> done=1 in cycle k+5, result=32'h00000001.
REQ-026 SRA: data_in=32'h80000000, shamt=4, arith=1 -> result=32'hF8000000; data_in=32'h7FFFFFF0, shamt=4, arith=1 -> 32'h07FFFFFF.
REQ-027 shamt=0: data_in=32'hDEADBEEF, arith=1 -> result=32'hDEADBEEF after the full 5-cycle latency, with a single done pulse.
REQ-028 start with data_in=32'hFFFFFFFF asserted during SHIFT of (32'h000000F0, shamt=4, arith=0) -> ignored; result=32'h0000000F; ready=0 throughout SHIFT.
REQ-029 Reset pulse at edge k+2 of an operation -> result=0, done=0, ready=1 immediately; no done pulse afterwards until a new start.
REQ-030 Back-to-back: start held high in the DONE cycle with (32'h00000100, shamt=8, arith=0) -> the second done occurs 5 cycles later with result=32'h00000001; the first result is held until that second start is accepted.
